cordic_request_arbiter: RTL

//  Shares one pipelined, in-order CORDIC core between N_REQ requesters.

---
 rtl/cordic_request_arbiter.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/cordic_request_arbiter.sv
// cordic_request_arbiter
// Shares one pipelined, in-order CORDIC core between N_REQ requesters.
// A round-robin arbiter issues at most one operation per cycle. An ID FIFO
// records which requester owns each in-flight operation, so every core
// result can be strobed back to the requester that issued it.

module cordic_request_arbiter #(
  parameter int N_REQ           = 4,
  parameter int BITS            = 33,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic [N_REQ-1:0]                     i_req_valid,
  output logic [N_REQ-1:0]                     o_req_ready,
  input  logic [N_REQ*BITS-1:0]                i_req_x,
  input  logic [N_REQ*BITS-1:0]                i_req_y,
  input  logic [N_REQ*BITS-1:0]                i_req_z,
  input  logic [N_REQ*2-1:0]                   i_req_mode,
  input  logic [N_REQ-1:0]                     i_req_rot_en,
  output logic                                 o_cdc_start,
  output logic [BITS-1:0]                      o_cdc_x,
  output logic [BITS-1:0]                      o_cdc_y,
  output logic [BITS-1:0]                      o_cdc_z,
  output logic [1:0]                           o_cdc_mode,
  output logic                                 o_cdc_rot_en,
  input  logic                                 i_cdc_valid,
  input  logic [BITS-1:0]                      i_cdc_x,
  input  logic [BITS-1:0]                      i_cdc_y,
  input  logic [BITS-1:0]                      i_cdc_z,
  output logic [N_REQ-1:0]                     o_rsp_valid,
  output logic [BITS-1:0]                      o_rsp_x,
  output logic [BITS-1:0]                      o_rsp_y,
  output logic [BITS-1:0]                      o_rsp_z,
  output logic [$clog2(MAX_OUTSTANDING):0]     o_outstanding,
  output logic                                 o_err
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int AW  = $clog2(MAX_OUTSTANDING);
  localparam int CW  = AW + 1;

  // Round-robin pointer and ID FIFO state
  logic [IDW-1:0]  r_ptr;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [IDW-1:0]  r_id_mem [MAX_OUTSTANDING];

  // Issue and response registers
  logic            r_cdc_start;
  logic [BITS-1:0] r_cdc_x;
  logic [BITS-1:0] r_cdc_y;
  logic [BITS-1:0] r_cdc_z;
  logic [1:0]      r_cdc_mode;
  logic            r_cdc_rot_en;
  logic [N_REQ-1:0] r_rsp_valid;
  logic [BITS-1:0] r_rsp_x;
  logic [BITS-1:0] r_rsp_y;
  logic [BITS-1:0] r_rsp_z;
  logic            r_err;

  // Per-requester operand views
  logic [BITS-1:0] w_req_x    [N_REQ];
  logic [BITS-1:0] w_req_y    [N_REQ];
  logic [BITS-1:0] w_req_z    [N_REQ];
  logic [1:0]      w_req_mode [N_REQ];

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [IDW-1:0]  w_head;
  logic            w_grant_any;
  logic [IDW-1:0]  w_grant_idx;
  logic [N_REQ-1:0] w_grant;
  logic [IDW:0]    w_sum;
  logic [IDW-1:0]  w_idx;

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign w_req_x[k]    = i_req_x[k*BITS +: BITS];
    assign w_req_y[k]    = i_req_y[k*BITS +: BITS];
    assign w_req_z[k]    = i_req_z[k*BITS +: BITS];
    assign w_req_mode[k] = i_req_mode[k*2 +: 2];
  end

  // The full check uses the pre-pop count: a slot freed this cycle is
  // not reusable until the next one.
  assign w_full  = (r_count == CW'(MAX_OUTSTANDING));
  assign w_empty = (r_count == '0);
  assign w_push  = w_grant_any;
  assign w_pop   = i_cdc_valid && !w_empty;
  assign w_head  = r_id_mem[r_rd_ptr];

  // Round-robin scan starting at r_ptr, wrapping at N_REQ
  always_comb begin
    w_grant     = '0;
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_sum       = '0;
    w_idx       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_sum = {1'b0, r_ptr} + (IDW+1)'(i);
      if (w_sum >= (IDW+1)'(N_REQ)) begin
        w_sum = w_sum - (IDW+1)'(N_REQ);
      end
      w_idx = w_sum[IDW-1:0];
      if (!w_full && !w_grant_any && i_req_valid[w_idx]) begin
        w_grant_any = 1'b1;
        w_grant_idx = w_idx;
      end
    end
    if (w_grant_any) begin
      w_grant[w_grant_idx] = 1'b1;
    end
  end

  // Pointer moves past the winner; it holds when nobody is granted
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (w_grant_any) begin
      r_ptr <= (w_grant_idx == IDW'(N_REQ-1)) ? '0 : w_grant_idx + 1'b1;
    end
  end

  // ID FIFO pointers and in-flight count
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ID storage; contents are don't-care while the FIFO is empty
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_id_mem[r_wr_ptr] <= w_grant_idx;
    end
  end

  // Register the granted operands toward the core
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cdc_start  <= 1'b0;
      r_cdc_x      <= '0;
      r_cdc_y      <= '0;
      r_cdc_z      <= '0;
      r_cdc_mode   <= '0;
      r_cdc_rot_en <= 1'b0;
    end else begin
      r_cdc_start <= w_grant_any;
      if (w_grant_any) begin
        r_cdc_x      <= w_req_x[w_grant_idx];
        r_cdc_y      <= w_req_y[w_grant_idx];
        r_cdc_z      <= w_req_z[w_grant_idx];
        r_cdc_mode   <= w_req_mode[w_grant_idx];
        r_cdc_rot_en <= i_req_rot_en[w_grant_idx];
      end
    end
  end

  // Route each core result to the head ID; flag results with no owner
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rsp_valid <= '0;
      r_rsp_x     <= '0;
      r_rsp_y     <= '0;
      r_rsp_z     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      if (w_pop) begin
        r_rsp_valid[w_head] <= 1'b1;
        r_rsp_x             <= i_cdc_x;
        r_rsp_y             <= i_cdc_y;
        r_rsp_z             <= i_cdc_z;
      end
      if (i_cdc_valid && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_req_ready   = w_grant;
  assign o_cdc_start   = r_cdc_start;
  assign o_cdc_x       = r_cdc_x;
  assign o_cdc_y       = r_cdc_y;
  assign o_cdc_z       = r_cdc_z;
  assign o_cdc_mode    = r_cdc_mode;
  assign o_cdc_rot_en  = r_cdc_rot_en;
  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_x       = r_rsp_x;
  assign o_rsp_y       = r_rsp_y;
  assign o_rsp_z       = r_rsp_z;
  assign o_outstanding = r_count;
  assign o_err         = r_err;

endmodule
